// File: rtl/free_list_if.sv
// Rename/commit-side bundle for the physical register free list.
// The master drives requests and returned tags; the slave is the free list itself.
interface free_list_if #(
  parameter int unsigned PHY_WIDTH = 6
);
  logic                 valid;
  logic [PHY_WIDTH-1:0] rd_phy_new;
  logic                 empty;
  logic                 commit_valid;
  logic                 release_valid;
  logic [PHY_WIDTH-1:0] release_phy;
  logic                 flush;
  logic [PHY_WIDTH:0]   free_count;
  logic                 overflow_err;

  modport master (
    output valid, commit_valid, release_valid, release_phy, flush,
    input  rd_phy_new, empty, free_count, overflow_err
  );

  modport slave (
    input  valid, commit_valid, release_valid, release_phy, flush,
    output rd_phy_new, empty, free_count, overflow_err
  );
endinterface

// File: rtl/free_list.sv
// Circular FIFO of free physical register tags with a speculative allocation head
// and a committed head used to roll back speculative allocations on flush.
module free_list #(
  parameter int unsigned ARCH_REGS = 32,
  parameter int unsigned PHY_REGS  = 64,
  parameter int unsigned PHY_WIDTH = 6
) (
  input logic         clk,
  input logic         rst,
  free_list_if.slave  fl
);

  // Extra MSB is the wrap flag, so full and empty are distinguishable.
  typedef logic [PHY_WIDTH:0] ptr_t;

  logic [PHY_WIDTH-1:0] mem_q [PHY_REGS];
  ptr_t spec_head_q, spec_head_d;
  ptr_t commit_head_q, commit_head_d;
  ptr_t tail_q, tail_d;
  logic overflow_q, overflow_d;

  ptr_t occupancy;
  ptr_t free_count;
  logic empty;
  logic full;
  logic do_write;

  assign occupancy  = tail_q - commit_head_q;
  assign full       = (occupancy == ptr_t'(PHY_REGS));
  assign free_count = tail_q - spec_head_q;
  assign empty      = (free_count == '0);
  assign do_write   = fl.release_valid && !full;

  always_comb begin
    commit_head_d = commit_head_q + ptr_t'(fl.commit_valid);

    spec_head_d = spec_head_q;
    // Flush restores to the head as updated by any same-cycle commit.
    if (fl.flush) begin
      spec_head_d = commit_head_d;
    end else if (fl.valid && !empty) begin
      spec_head_d = spec_head_q + ptr_t'(1);
    end

    tail_d     = do_write ? tail_q + ptr_t'(1) : tail_q;
    overflow_d = overflow_q | (fl.release_valid & full);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      spec_head_q   <= '0;
      commit_head_q <= '0;
      tail_q        <= ptr_t'(PHY_REGS - ARCH_REGS);
      overflow_q    <= 1'b0;
      for (int unsigned i = 0; i < PHY_REGS; i++) begin
        mem_q[i] <= (i < PHY_REGS - ARCH_REGS) ? PHY_WIDTH'(ARCH_REGS + i) : '0;
      end
    end else begin
      spec_head_q   <= spec_head_d;
      commit_head_q <= commit_head_d;
      tail_q        <= tail_d;
      overflow_q    <= overflow_d;
      if (do_write) begin
        mem_q[tail_q[PHY_WIDTH-1:0]] <= fl.release_phy;
      end
    end
  end

  assign fl.rd_phy_new   = mem_q[spec_head_q[PHY_WIDTH-1:0]];
  assign fl.empty        = empty;
  assign fl.free_count   = free_count;
  assign fl.overflow_err = overflow_q;

endmodule

// File: tb/tb_free_list.sv
// Self-checking bench for free_list: directed scenarios plus a randomized
// allocate/commit/release/flush run against a queue-based reference model.
module tb_free_list;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  free_list_if #(.PHY_WIDTH(6)) bus ();

  free_list #(
    .ARCH_REGS(32),
    .PHY_REGS (64),
    .PHY_WIDTH(6)
  ) dut (
    .clk(clk),
    .rst(rst),
    .fl (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Model: pool holds the tags between the committed head and the tail, oldest first;
  // the first n_spec of them are speculatively allocated.
  logic [5:0] pool[$];
  int         n_spec;
  bit         ovf_m;
  logic [5:0] mapped[$];

  function automatic int model_free();
    return pool.size() - n_spec;
  endfunction

  task automatic model_init();
    pool.delete();
    for (int i = 32; i < 64; i++) pool.push_back(6'(i));
    n_spec = 0;
    ovf_m  = 1'b0;
    mapped.delete();
    for (int i = 0; i < 32; i++) mapped.push_back(6'(i));
  endtask

  task automatic idle_inputs();
    bus.valid = 1'b0; bus.commit_valid = 1'b0; bus.release_valid = 1'b0;
    bus.release_phy = '0; bus.flush = 1'b0;
  endtask

  // One clock with the given inputs; the model advances from its pre-edge state.
  task automatic drive(input bit v, input bit c, input bit r, input logic [5:0] t,
                       input bit f);
    bit emp;
    bit full;
    bus.valid = v; bus.commit_valid = c; bus.release_valid = r;
    bus.release_phy = t; bus.flush = f;
    emp  = (model_free() == 0);
    full = (pool.size() == 64);
    if (c) begin
      void'(pool.pop_front());
      n_spec--;
    end
    if (v && !emp && !f) n_spec++;
    if (f) n_spec = 0;
    if (r) begin
      if (full) ovf_m = 1'b1;
      else pool.push_back(t);
    end
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    idle_inputs();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_init();
  endtask

  task automatic test_reset();
    apply_reset();
    drive(0, 0, 0, '0, 0);
    n_checks++; if (bus.rd_phy_new !== 6'd32)
      $display("FAIL reset_rd: got %0d want 32", bus.rd_phy_new); else n_pass++;
    n_checks++; if (bus.free_count !== 7'd32)
      $display("FAIL reset_free_count: got %0d want 32", bus.free_count); else n_pass++;
    n_checks++; if (bus.empty !== 1'b0)
      $display("FAIL reset_empty: got %0b want 0", bus.empty); else n_pass++;
    n_checks++; if (bus.overflow_err !== 1'b0)
      $display("FAIL reset_overflow: got %0b want 0", bus.overflow_err); else n_pass++;
  endtask

  task automatic test_drain();
    for (int i = 0; i < 32; i++) begin
      n_checks++; if (bus.rd_phy_new !== 6'(32 + i))
        $display("FAIL drain_tag_%0d: got %0d want %0d", i, bus.rd_phy_new, 32 + i);
      else n_pass++;
      drive(1, 0, 0, '0, 0);
    end
    n_checks++; if (bus.empty !== 1'b1)
      $display("FAIL drain_empty: got %0b want 1", bus.empty); else n_pass++;
    n_checks++; if (bus.free_count !== 7'd0)
      $display("FAIL drain_free_count: got %0d want 0", bus.free_count); else n_pass++;
    drive(1, 0, 0, '0, 0);
    n_checks++; if (bus.empty !== 1'b1 || bus.free_count !== 7'd0)
      $display("FAIL drain_extra_valid: got empty=%0b count=%0d want empty=1 count=0",
               bus.empty, bus.free_count);
    else n_pass++;
  endtask

  task automatic test_release_while_empty();
    drive(1, 0, 1, 6'd5, 0);
    n_checks++; if (bus.rd_phy_new !== 6'd5)
      $display("FAIL rel_empty_rd: got %0d want 5", bus.rd_phy_new); else n_pass++;
    n_checks++; if (bus.free_count !== 7'd1)
      $display("FAIL rel_empty_free_count: got %0d want 1", bus.free_count); else n_pass++;
    n_checks++; if (bus.empty !== 1'b0)
      $display("FAIL rel_empty_empty: got %0b want 0", bus.empty); else n_pass++;
  endtask

  task automatic test_flush(input bit commit_with_flush);
    int want_rd;
    int want_fc;
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      n_checks++; if (bus.rd_phy_new !== 6'(32 + i))
        $display("FAIL flush_alloc_%0d: got %0d want %0d", i, bus.rd_phy_new, 32 + i);
      else n_pass++;
      drive(1, 0, 0, '0, 0);
    end
    for (int i = 0; i < 3; i++) drive(0, 1, 0, '0, 0);
    drive(0, commit_with_flush, 0, '0, 1);
    want_rd = commit_with_flush ? 36 : 35;
    want_fc = commit_with_flush ? 28 : 29;
    n_checks++; if (bus.rd_phy_new !== 6'(want_rd))
      $display("FAIL flush_rd(c=%0b): got %0d want %0d", commit_with_flush,
               bus.rd_phy_new, want_rd);
    else n_pass++;
    n_checks++; if (bus.free_count !== 7'(want_fc))
      $display("FAIL flush_free_count(c=%0b): got %0d want %0d", commit_with_flush,
               bus.free_count, want_fc);
    else n_pass++;
  endtask

  task automatic test_random();
    bit v, c, f;
    logic [5:0] t;
    apply_reset();
    for (int cyc = 0; cyc < 200; cyc++) begin
      n_checks++; if (bus.free_count !== 7'(model_free()))
        $display("FAIL rand_free_count@%0d: got %0d want %0d", cyc, bus.free_count,
                 model_free());
      else n_pass++;
      n_checks++; if (bus.empty !== (model_free() == 0))
        $display("FAIL rand_empty@%0d: got %0b want %0b", cyc, bus.empty, model_free() == 0);
      else n_pass++;
      if (model_free() != 0) begin
        n_checks++; if (bus.rd_phy_new !== pool[n_spec])
          $display("FAIL rand_tag@%0d: got %0d want %0d", cyc, bus.rd_phy_new, pool[n_spec]);
        else n_pass++;
      end
      n_checks++; if (bus.overflow_err !== 1'b0)
        $display("FAIL rand_overflow@%0d: got %0b want 0", cyc, bus.overflow_err);
      else n_pass++;
      v = 1'($urandom % 2);
      c = (n_spec > 0) && (($urandom % 2) == 0);
      f = (($urandom % 16) == 0);
      t = '0;
      // Committed tag becomes the arch mapping; the displaced mapping is released.
      if (c) begin
        t = mapped.pop_front();
        mapped.push_back(pool[0]);
      end
      drive(v, c, c, t, f);
    end
  endtask

  task automatic test_overflow();
    logic [6:0] fc_before;
    while (pool.size() < 64) drive(0, 0, 1, 6'($urandom % 64), 0);
    n_checks++; if (bus.overflow_err !== 1'b0)
      $display("FAIL ovf_at_bound: got %0b want 0", bus.overflow_err); else n_pass++;
    n_checks++; if (bus.free_count !== 7'(model_free()))
      $display("FAIL ovf_fill_count: got %0d want %0d", bus.free_count, model_free());
    else n_pass++;
    fc_before = 7'(model_free());
    drive(0, 0, 1, 6'd7, 0);
    n_checks++; if (bus.overflow_err !== 1'b1)
      $display("FAIL ovf_set: got %0b want 1", bus.overflow_err); else n_pass++;
    n_checks++; if (bus.free_count !== fc_before)
      $display("FAIL ovf_dropped: got %0d want %0d", bus.free_count, fc_before); else n_pass++;
    drive(0, 0, 0, '0, 0);
    n_checks++; if (bus.overflow_err !== 1'b1)
      $display("FAIL ovf_sticky: got %0b want 1", bus.overflow_err); else n_pass++;
  endtask

  task automatic test_reset_mid();
    bus.valid = 1'b1; bus.commit_valid = 1'b1; bus.release_valid = 1'b1;
    bus.release_phy = 6'd9; bus.flush = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    idle_inputs();
    model_init();
    n_checks++; if (bus.rd_phy_new !== 6'd32 || bus.free_count !== 7'd32)
      $display("FAIL rst_mid_state: got rd=%0d count=%0d want rd=32 count=32",
               bus.rd_phy_new, bus.free_count);
    else n_pass++;
    n_checks++; if (bus.overflow_err !== 1'b0 || bus.empty !== 1'b0)
      $display("FAIL rst_mid_flags: got ovf=%0b empty=%0b want 0/0",
               bus.overflow_err, bus.empty);
    else n_pass++;
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_drain();
    test_release_while_empty();
    test_flush(1'b0);
    test_flush(1'b1);
    test_random();
    test_overflow();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
